triangle_monitor: RTL and testbench

//  Receive-side checker for triangle-wave sample streams (0 -> 2^N-1 -> 0, step +/-1 per valid sample).

---
 rtl/triangle_monitor.sv | 191 +++++++++++++++++++
 tb/tb_triangle_monitor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/triangle_monitor.sv
// Receive-side checker for triangle-wave sample streams: locks onto ramp direction,
// flags peaks/troughs, measures trough-to-trough period and counts step errors.
module triangle_monitor #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N-1:0]     in,
    output logic             locked,
    output logic             dir,
    output logic             peak,
    output logic             trough,
    output logic             error,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N+1:0]     period,
    output logic             period_vld
);

    typedef enum logic [1:0] {StAcquire, StSync, StUp, StDown} state_e;

    localparam logic [N:0]       StepOne = 1;
    localparam logic [N+1:0]     CntOne  = 1;
    localparam logic [CNT_W-1:0] ErrOne  = 1;

    state_e state_q, state_d;

    logic [N-1:0]     prev_q;
    logic [N+1:0]     cnt_q, cnt_d;
    logic             have_trough_q, have_trough_d;

    logic             locked_d, dir_d, peak_d, trough_d, error_d, period_vld_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic [N+1:0]     period_d;

    logic [N:0] in_ext, prev_ext, prev_inc, prev_dec;
    logic       up_step, dn_step, at_max, at_zero, state_locked;

    // Compares are one bit wider than the sample so MAX->0 and 0->MAX never match a step.
    assign in_ext   = {1'b0, in};
    assign prev_ext = {1'b0, prev_q};
    assign prev_inc = prev_ext + StepOne;
    assign prev_dec = prev_ext - StepOne;
    assign up_step  = (in_ext == prev_inc);
    assign dn_step  = (in_ext == prev_dec);
    assign at_max   = (in == {N{1'b1}});
    assign at_zero  = (in == '0);

    assign state_locked = (state_q == StUp) || (state_q == StDown);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAcquire;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                StAcquire: state_d = StSync;
                StSync: begin
                    if (up_step) begin
                        state_d = at_max ? StDown : StUp;
                    end else if (dn_step) begin
                        state_d = at_zero ? StUp : StDown;
                    end
                end
                StUp: begin
                    if (up_step) begin
                        state_d = at_max ? StDown : StUp;
                    end else begin
                        state_d = StSync;
                    end
                end
                StDown: begin
                    if (dn_step) begin
                        state_d = at_zero ? StUp : StDown;
                    end else begin
                        state_d = StSync;
                    end
                end
                default: state_d = StAcquire;
            endcase
        end
    end

    // Output / datapath next-state logic
    always_comb begin
        peak_d        = 1'b0;
        trough_d      = 1'b0;
        error_d       = 1'b0;
        locked_d      = locked;
        dir_d         = dir;
        cnt_d         = cnt_q;
        have_trough_d = have_trough_q;
        period_d      = period;
        period_vld_d  = period_vld;
        err_cnt_d     = err_cnt;

        if (ena) begin
            unique case (state_q)
                StSync: begin
                    if (up_step && at_max) begin
                        peak_d = 1'b1;
                    end else if (dn_step && at_zero) begin
                        trough_d = 1'b1;
                    end
                end
                StUp: begin
                    if (!up_step) begin
                        error_d = 1'b1;
                    end else if (at_max) begin
                        peak_d = 1'b1;
                    end
                end
                StDown: begin
                    if (!dn_step) begin
                        error_d = 1'b1;
                    end else if (at_zero) begin
                        trough_d = 1'b1;
                    end
                end
                default: ;
            endcase

            locked_d = (state_d == StUp) || (state_d == StDown);
            if (state_d == StUp) begin
                dir_d = 1'b1;
            end else if (state_d == StDown) begin
                dir_d = 1'b0;
            end

            if (error_d) begin
                if (err_cnt != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt + ErrOne;
                end
                period_vld_d  = 1'b0;
                have_trough_d = 1'b0;
                cnt_d         = '0;
            end else if (trough_d) begin
                // The trough sample itself closes the period, hence +1.
                if (have_trough_q) begin
                    period_d     = cnt_q + CntOne;
                    period_vld_d = 1'b1;
                end
                cnt_d         = '0;
                have_trough_d = 1'b1;
            end else if (state_locked && (cnt_q != {(N+2){1'b1}})) begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q        <= '0;
            cnt_q         <= '0;
            have_trough_q <= 1'b0;
            locked        <= 1'b0;
            dir           <= 1'b0;
            peak          <= 1'b0;
            trough        <= 1'b0;
            error         <= 1'b0;
            err_cnt       <= '0;
            period        <= '0;
            period_vld    <= 1'b0;
        end else begin
            if (ena) begin
                prev_q <= in;
            end
            cnt_q         <= cnt_d;
            have_trough_q <= have_trough_d;
            locked        <= locked_d;
            dir           <= dir_d;
            peak          <= peak_d;
            trough        <= trough_d;
            error         <= error_d;
            err_cnt       <= err_cnt_d;
            period        <= period_d;
            period_vld    <= period_vld_d;
        end
    end

endmodule

// File: tb/tb_triangle_monitor.sv
// Bench for triangle_monitor: N=8 and N=4 instances checked every cycle against an
// integer-level reference model, plus literal checkpoints.
module tb_triangle_monitor;

    localparam int ACQ = 0, SYNC = 1, UP = 2, DOWN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v[2];
    logic       ena_v[2];
    logic [7:0] in_v[2];

    logic       a_locked, a_dir, a_peak, a_trough, a_error, a_pvld;
    logic [7:0] a_errcnt;
    logic [9:0] a_period;

    logic       b_locked, b_dir, b_peak, b_trough, b_error, b_pvld;
    logic [7:0] b_errcnt;
    logic [5:0] b_period;
    logic [3:0] b_in;
    assign b_in = in_v[1][3:0];

    triangle_monitor #(.N(8), .CNT_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst_v[0]),
        .ena       (ena_v[0]),
        .in        (in_v[0]),
        .locked    (a_locked),
        .dir       (a_dir),
        .peak      (a_peak),
        .trough    (a_trough),
        .error     (a_error),
        .err_cnt   (a_errcnt),
        .period    (a_period),
        .period_vld(a_pvld)
    );

    triangle_monitor #(.N(4), .CNT_W(8)) u_dut_b (
        .clk       (clk),
        .rst       (rst_v[1]),
        .ena       (ena_v[1]),
        .in        (b_in),
        .locked    (b_locked),
        .dir       (b_dir),
        .peak      (b_peak),
        .trough    (b_trough),
        .error     (b_error),
        .err_cnt   (b_errcnt),
        .period    (b_period),
        .period_vld(b_pvld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model, one slot per instance
    int maxv[2]   = '{255, 15};
    int cntmax[2] = '{1023, 63};
    int ecmax     = 255;
    int m_st[2], m_prev[2], m_cnt[2], m_have[2];
    int m_lk[2], m_dir[2], m_pk[2], m_tr[2], m_er[2], m_ec[2], m_per[2], m_pv[2];
    bit chk_en[2] = '{1'b0, 1'b0};

    task automatic model_step(input int k, input bit r, input bit e, input int v);
        int  mx;
        bit  up, dn, was_lk;
        mx = maxv[k];
        if (r) begin
            m_st[k] = ACQ;  m_prev[k] = 0; m_cnt[k] = 0; m_have[k] = 0;
            m_lk[k] = 0;    m_dir[k] = 0;  m_pk[k] = 0;  m_tr[k] = 0;  m_er[k] = 0;
            m_ec[k] = 0;    m_per[k] = 0;  m_pv[k] = 0;
            chk_en[k] = 1'b1;
            return;
        end
        m_pk[k] = 0; m_tr[k] = 0; m_er[k] = 0;
        if (!e) return;
        up     = (v == m_prev[k] + 1);
        dn     = (v == m_prev[k] - 1);
        was_lk = (m_st[k] == UP) || (m_st[k] == DOWN);
        case (m_st[k])
            ACQ:  m_st[k] = SYNC;
            SYNC: begin
                if (up) begin
                    if (v == mx) begin m_pk[k] = 1; m_st[k] = DOWN; end
                    else m_st[k] = UP;
                end else if (dn) begin
                    if (v == 0) begin m_tr[k] = 1; m_st[k] = UP; end
                    else m_st[k] = DOWN;
                end
            end
            UP: begin
                if (up && v == mx) begin m_pk[k] = 1; m_st[k] = DOWN; end
                else if (!up) begin m_er[k] = 1; m_st[k] = SYNC; end
            end
            default: begin
                if (dn && v == 0) begin m_tr[k] = 1; m_st[k] = UP; end
                else if (!dn) begin m_er[k] = 1; m_st[k] = SYNC; end
            end
        endcase
        m_prev[k] = v;
        if (m_er[k] != 0) begin
            if (m_ec[k] < ecmax) m_ec[k]++;
            m_pv[k] = 0; m_have[k] = 0; m_cnt[k] = 0;
        end else if (m_tr[k] != 0) begin
            if (m_have[k] != 0) begin m_per[k] = m_cnt[k] + 1; m_pv[k] = 1; end
            m_cnt[k] = 0; m_have[k] = 1;
        end else if (was_lk && m_cnt[k] < cntmax[k]) begin
            m_cnt[k]++;
        end
        m_lk[k] = (m_st[k] == UP || m_st[k] == DOWN) ? 1 : 0;
        if (m_st[k] == UP) m_dir[k] = 1;
        else if (m_st[k] == DOWN) m_dir[k] = 0;
    endtask

    always @(posedge clk) begin
        model_step(0, rst_v[0], ena_v[0], int'(in_v[0]));
        model_step(1, rst_v[1], ena_v[1], int'(in_v[1][3:0]));
    end

    task automatic cmp(input int k, input int lk, input int dr, input int pk, input int tr,
                       input int er, input int ec, input int per, input int pv);
        string p;
        p = (k == 0) ? "a" : "b";
        chk({p, ".locked"}, lk, m_lk[k]);
        chk({p, ".dir"}, dr, m_dir[k]);
        chk({p, ".peak"}, pk, m_pk[k]);
        chk({p, ".trough"}, tr, m_tr[k]);
        chk({p, ".error"}, er, m_er[k]);
        chk({p, ".err_cnt"}, ec, m_ec[k]);
        chk({p, ".period"}, per, m_per[k]);
        chk({p, ".period_vld"}, pv, m_pv[k]);
    endtask

    always @(negedge clk) begin
        if (chk_en[0])
            cmp(0, int'(a_locked), int'(a_dir), int'(a_peak), int'(a_trough), int'(a_error),
                int'(a_errcnt), int'(a_period), int'(a_pvld));
        if (chk_en[1])
            cmp(1, int'(b_locked), int'(b_dir), int'(b_peak), int'(b_trough), int'(b_error),
                int'(b_errcnt), int'(b_period), int'(b_pvld));
    end

    // Stimulus helpers; inputs always change 1 time unit after a rising edge
    task automatic put(input int k, input int v, input int gap_pct);
        for (int i = 0; i < 8 && $urandom_range(99) < gap_pct; i++) begin
            ena_v[k] = 1'b0;
            in_v[k]  = 8'($urandom);
            @(posedge clk); #1;
        end
        ena_v[k] = 1'b1;
        in_v[k]  = 8'(v);
        @(posedge clk); #1;
        ena_v[k] = 1'b0;
    endtask

    task automatic ramp(input int k, input int from, input int to, input int gap_pct);
        int s;
        s = (to >= from) ? 1 : -1;
        for (int v = from; v != to + s; v += s) put(k, v, gap_pct);
    endtask

    task automatic full_cycles(input int k, input int mx, input int gap_pct);
        ramp(k, 0, mx, gap_pct);
        ramp(k, mx - 1, 0, gap_pct);
        ramp(k, 1, mx, gap_pct);
        ramp(k, mx - 1, 0, gap_pct);
    endtask

    task automatic do_reset(input int k);
        rst_v[k] = 1'b1;
        ena_v[k] = 1'($urandom);
        in_v[k]  = 8'($urandom);
        @(posedge clk); #1;
        rst_v[k] = 1'b0;
        ena_v[k] = 1'b0;
    endtask

    initial begin
        int v, s;
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1;
            ena_v[k] = 1'b0;
            in_v[k]  = 8'd0;
        end
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        chk("reset.locked", int'(a_locked), 0);
        chk("reset.period", int'(a_period), 0);
        chk("reset.err_cnt", int'(a_errcnt), 0);

        // Ideal stream, no gaps
        put(0, 0, 0);
        put(0, 1, 0);
        chk("t1.locked_after_2nd", int'(a_locked), 1);
        ramp(0, 2, 255, 0);
        chk("t1.peak_at_max", int'(a_peak), 1);
        ramp(0, 254, 0, 0);
        chk("t1.first_trough", int'(a_trough), 1);
        chk("t1.pvld_after_first_trough", int'(a_pvld), 0);
        ramp(0, 1, 255, 0);
        ramp(0, 254, 0, 0);
        chk("t1.period", int'(a_period), 510);
        chk("t1.period_vld", int'(a_pvld), 1);
        chk("t1.err_cnt", int'(a_errcnt), 0);

        // Same stream with ena gaps
        do_reset(0);
        full_cycles(0, 255, 50);
        chk("t2.period", int'(a_period), 510);
        chk("t2.period_vld", int'(a_pvld), 1);
        chk("t2.err_cnt", int'(a_errcnt), 0);

        // Bad step on the up ramp
        do_reset(0);
        ramp(0, 0, 99, 0);
        put(0, 102, 0);
        chk("t3.error", int'(a_error), 1);
        chk("t3.err_cnt", int'(a_errcnt), 1);
        chk("t3.locked", int'(a_locked), 0);
        ramp(0, 101, 255, 0);
        chk("t3.pvld_no_troughs", int'(a_pvld), 0);

        // No wrap-around accepted
        do_reset(0);
        put(0, 254, 0);
        put(0, 255, 0);
        chk("t4.peak", int'(a_peak), 1);
        chk("t4.locked", int'(a_locked), 1);
        put(0, 0, 0);
        chk("t4.wrap_error", int'(a_error), 1);
        chk("t4.wrap_unlocked", int'(a_locked), 0);
        put(0, 1, 0);
        chk("t4.relock", int'(a_locked), 1);
        chk("t4.dir_up", int'(a_dir), 1);

        // Reset mid-ramp
        do_reset(0);
        ramp(0, 0, 76, 0);
        rst_v[0] = 1'b1;
        ena_v[0] = 1'b1;
        in_v[0]  = 8'd77;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        ena_v[0] = 1'b0;
        chk("t5.locked", int'(a_locked), 0);
        chk("t5.dir", int'(a_dir), 0);
        chk("t5.err_cnt", int'(a_errcnt), 0);
        ramp(0, 78, 255, 0);
        ramp(0, 254, 0, 0);
        ramp(0, 1, 255, 0);
        ramp(0, 254, 0, 0);
        chk("t5.period", int'(a_period), 510);
        chk("t5.err_cnt_end", int'(a_errcnt), 0);

        // Mostly-valid random walk with occasional faults
        do_reset(0);
        v = 0;
        s = 1;
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(19);
            if (r < 17) begin
                if (v + s > 255 || v + s < 0) s = -s;
                v = v + s;
            end else if (r == 17) begin
                v = $urandom_range(255);
            end else begin
                s = -s;
                if (v + s >= 0 && v + s <= 255) v = v + s;
            end
            put(0, v, 30);
        end

        // Small instance: period 2*15 and error counter saturation
        do_reset(1);
        full_cycles(1, 15, 20);
        chk("t6.period", int'(b_period), 30);
        chk("t6.period_vld", int'(b_pvld), 1);
        for (int i = 0; i < 300; i++) begin
            put(1, 2, 0);
            put(1, 3, 0);
            put(1, 7, 0);
        end
        chk("t6.err_cnt_sat", int'(b_errcnt), 255);
        chk("t6.pvld_cleared", int'(b_pvld), 0);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
